// File: rtl/rv_decode_stage.sv
// RISC-V base-ISA decode stage: field split, format/immediate/illegal decode,
// and a 2-entry valid/ready skid buffer with flush and a retired-decode counter.
module rv_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       func3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       func7,
  output logic [2:0]       fmt,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);

  localparam int unsigned ILEN = 32;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  state_e          state_q, state_d;
  entry_t          head_q, head_d;
  entry_t          skid_q, skid_d;
  entry_t          dec_c;
  logic            in_ready_q, out_valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ILEN-1:0] imm32_c;
  logic            acc_c, pop_c;

  // Combinational decode of the offered word into a full buffer record.
  always_comb begin
    dec_c         = '0;
    imm32_c       = '0;
    dec_c.instr   = instruction;
    dec_c.fmt     = FMT_NONE;
    dec_c.illegal = 1'b1;
    if (instruction[1:0] == 2'b11) begin
      dec_c.illegal = 1'b0;
      case (instruction[6:0])
        7'b0110011:                                    dec_c.fmt = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111,
        7'b0001111, 7'b1110011:                        dec_c.fmt = FMT_I;
        7'b0100011:                                    dec_c.fmt = FMT_S;
        7'b1100011:                                    dec_c.fmt = FMT_B;
        7'b0110111, 7'b0010111:                        dec_c.fmt = FMT_U;
        7'b1101111:                                    dec_c.fmt = FMT_J;
        default: begin
          dec_c.fmt     = FMT_NONE;
          dec_c.illegal = 1'b1;
        end
      endcase
    end
    case (dec_c.fmt)
      FMT_I: imm32_c = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S: imm32_c = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B: imm32_c = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: imm32_c = {instruction[31:12], 12'b0};
      FMT_J: imm32_c = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
      default: imm32_c = '0;
    endcase
    dec_c.imm = XLEN'($signed(imm32_c));
  end

  assign acc_c = in_valid & in_ready_q;
  assign pop_c = out_valid_q & out_ready;

  // Buffer next-state: head is the presented entry, skid holds the second.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = pop_c ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      EMPTY: if (acc_c) begin
        state_d = ONE;
        head_d  = dec_c;
      end
      ONE: begin
        if (acc_c && !pop_c) begin
          state_d = TWO;
          skid_d  = dec_c;
        end else if (acc_c && pop_c) begin
          head_d = dec_c;
        end else if (pop_c) begin
          state_d = EMPTY;
        end
      end
      TWO: if (pop_c) begin
        state_d = ONE;
        head_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign opcode    = head_q.instr[6:0];
  assign rd        = head_q.instr[11:7];
  assign func3     = head_q.instr[14:12];
  assign rs1       = head_q.instr[19:15];
  assign rs2       = head_q.instr[24:20];
  assign func7     = head_q.instr[31:25];
  assign fmt       = head_q.fmt;
  assign imm       = head_q.imm;
  assign illegal   = head_q.illegal;
  assign dec_count = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage (XLEN=32, CNT_W=4).
module tb_rv_decode_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  localparam logic [31:0] ADDI = 32'hFFB10093;
  localparam logic [31:0] SW   = 32'h00532423;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] LUI  = 32'h123451B7;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      instruction;
  logic [6:0]       opcode, func7;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       func3, fmt;
  logic [XLEN-1:0]  imm;
  logic             illegal;
  logic [CNT_W-1:0] dec_count;

  int               vecs = 0;
  int               errs = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  rv_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2), .func7(func7),
    .fmt(fmt), .imm(imm), .illegal(illegal), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    #3;
    vecs++; if ({out_valid, in_ready} !== 2'b01) begin errs++; $display("FAIL reset_hs got %b exp 01", {out_valid, in_ready}); end
    vecs++; if ({opcode, rd, func3, rs1, rs2, func7, fmt, illegal} !== 36'd0) begin errs++; $display("FAIL reset_fields got %h exp 0", {opcode, rd, func3, rs1, rs2, func7, fmt, illegal}); end
    vecs++; if ({imm, dec_count} !== '0) begin errs++; $display("FAIL reset_imm_cnt got %h/%h exp 0/0", imm, dec_count); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_addi();
    instruction = ADDI; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vecs++; if ({out_valid, fmt, rd, rs1, func3, illegal} !== {1'b1, 3'd1, 5'd1, 5'd2, 3'd0, 1'b0}) begin errs++; $display("FAIL addi_fields got v=%b fmt=%0d rd=%0d rs1=%0d f3=%0d ill=%b", out_valid, fmt, rd, rs1, func3, illegal); end
    vecs++; if (imm !== 32'hFFFFFFFB) begin errs++; $display("FAIL addi_imm got %h exp FFFFFFFB", imm); end
    vecs++; if (dec_count !== exp_cnt) begin errs++; $display("FAIL addi_cnt_before got %0d exp %0d", dec_count, exp_cnt); end
    step(); exp_cnt++;
    vecs++; if ({out_valid, dec_count} !== {1'b0, exp_cnt}) begin errs++; $display("FAIL addi_cnt_after got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, dec_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; out_ready = 1'b1;
    instruction = SW; step();
    vecs++; if ({in_ready, out_valid, fmt, rs2, rs1, func3, illegal} !== {1'b1, 1'b1, 3'd2, 5'd5, 5'd6, 3'd2, 1'b0}) begin errs++; $display("FAIL b2b_sw got rdy=%b v=%b fmt=%0d rs2=%0d rs1=%0d f3=%0d", in_ready, out_valid, fmt, rs2, rs1, func3); end
    vecs++; if (imm !== 32'd8) begin errs++; $display("FAIL b2b_sw_imm got %h exp 8", imm); end
    instruction = BEQ; step(); exp_cnt++;
    vecs++; if ({in_ready, out_valid, fmt, imm} !== {1'b1, 1'b1, 3'd3, 32'hFFFFFFFC}) begin errs++; $display("FAIL b2b_beq got rdy=%b v=%b fmt=%0d imm=%h", in_ready, out_valid, fmt, imm); end
    instruction = LUI; step(); exp_cnt++;
    in_valid = 1'b0;
    vecs++; if ({in_ready, out_valid, fmt, rd, imm} !== {1'b1, 1'b1, 3'd4, 5'd3, 32'h12345000}) begin errs++; $display("FAIL b2b_lui got rdy=%b v=%b fmt=%0d rd=%0d imm=%h", in_ready, out_valid, fmt, rd, imm); end
    step(); exp_cnt++;
    vecs++; if ({out_valid, dec_count} !== {1'b0, exp_cnt}) begin errs++; $display("FAIL b2b_end got v=%b cnt=%0d exp 0/%0d", out_valid, dec_count, exp_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    instruction = ADDI; step();
    vecs++; if ({in_ready, out_valid, opcode} !== {1'b1, 1'b1, 7'h13}) begin errs++; $display("FAIL bp_first got rdy=%b v=%b op=%h", in_ready, out_valid, opcode); end
    instruction = SW; step();
    vecs++; if ({in_ready, opcode} !== {1'b0, 7'h13}) begin errs++; $display("FAIL bp_full got rdy=%b op=%h exp 0/13", in_ready, opcode); end
    instruction = LUI; step();
    vecs++; if ({in_ready, opcode, imm} !== {1'b0, 7'h13, 32'hFFFFFFFB}) begin errs++; $display("FAIL bp_hold got rdy=%b op=%h imm=%h", in_ready, opcode, imm); end
    out_ready = 1'b1; step(); exp_cnt++;
    vecs++; if ({in_ready, out_valid, opcode, rs2} !== {1'b1, 1'b1, 7'h23, 5'd5}) begin errs++; $display("FAIL bp_second got rdy=%b v=%b op=%h rs2=%0d", in_ready, out_valid, opcode, rs2); end
    step(); exp_cnt++;
    in_valid = 1'b0;
    vecs++; if ({out_valid, opcode, rd} !== {1'b1, 7'h37, 5'd3}) begin errs++; $display("FAIL bp_third got v=%b op=%h rd=%0d", out_valid, opcode, rd); end
    step(); exp_cnt++;
    vecs++; if ({out_valid, dec_count} !== {1'b0, exp_cnt}) begin errs++; $display("FAIL bp_drain got v=%b cnt=%0d exp 0/%0d", out_valid, dec_count, exp_cnt); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1;
    instruction = 32'h00000000; step();
    instruction = 32'h0000007F;
    vecs++; if ({out_valid, illegal, fmt, opcode, imm} !== {1'b1, 1'b1, 3'd7, 7'h00, 32'h0}) begin errs++; $display("FAIL ill_zero got v=%b ill=%b fmt=%0d op=%h imm=%h", out_valid, illegal, fmt, opcode, imm); end
    step(); exp_cnt++;
    in_valid = 1'b0;
    vecs++; if ({out_valid, illegal, fmt, opcode, imm} !== {1'b1, 1'b1, 3'd7, 7'h7F, 32'h0}) begin errs++; $display("FAIL ill_7f got v=%b ill=%b fmt=%0d op=%h imm=%h", out_valid, illegal, fmt, opcode, imm); end
    step(); exp_cnt++;
    vecs++; if ({out_valid, dec_count} !== {1'b0, exp_cnt}) begin errs++; $display("FAIL ill_drain got v=%b cnt=%0d exp 0/%0d", out_valid, dec_count, exp_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    instruction = ADDI; step();
    instruction = SW; step();
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_pre_full got rdy=%b exp 0", in_ready); end
    flush = 1'b1; out_ready = 1'b1; instruction = LUI;
    step(); exp_cnt++;
    flush = 1'b0; in_valid = 1'b0;
    vecs++; if ({out_valid, in_ready, dec_count} !== {1'b0, 1'b1, exp_cnt}) begin errs++; $display("FAIL flush_post got v=%b rdy=%b cnt=%0d exp 0/1/%0d", out_valid, in_ready, dec_count, exp_cnt); end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if ({out_valid, dec_count} !== {1'b0, exp_cnt}) begin errs++; $display("FAIL flush_quiet%0d got v=%b cnt=%0d exp 0/%0d", i, out_valid, dec_count, exp_cnt); end
    end
  endtask

  task automatic test_wrap_and_reset();
    out_ready = 1'b1; in_valid = 1'b1; instruction = ADDI;
    repeat (5) step();
    in_valid = 1'b0;
    step(); exp_cnt = exp_cnt + CNT_W'(5);
    vecs++; if (dec_count !== exp_cnt) begin errs++; $display("FAIL cnt_allones got %0d exp %0d", dec_count, exp_cnt); end
    in_valid = 1'b1; step(); in_valid = 1'b0; step(); exp_cnt++;
    vecs++; if (dec_count !== exp_cnt) begin errs++; $display("FAIL cnt_wrap got %0d exp %0d", dec_count, exp_cnt); end
    out_ready = 1'b0; in_valid = 1'b1; instruction = SW;
    step(); step();
    #2 rst = 1'b1;
    #1;
    exp_cnt = '0;
    vecs++; if ({out_valid, in_ready, dec_count} !== {1'b0, 1'b1, exp_cnt}) begin errs++; $display("FAIL rst_mid_hs got v=%b rdy=%b cnt=%0d", out_valid, in_ready, dec_count); end
    vecs++; if ({opcode, rd, func3, rs1, rs2, func7, fmt, illegal, imm} !== 68'd0) begin errs++; $display("FAIL rst_mid_fields got %h exp 0", {opcode, rd, func3, rs1, rs2, func7, fmt, illegal, imm}); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    vecs++; if ({out_valid, dec_count} !== {1'b0, exp_cnt}) begin errs++; $display("FAIL rst_mid_lost got v=%b cnt=%0d exp 0/0", out_valid, dec_count); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Parametrised RISC-V base-ISA decode stage; successor to the single-format field splitter.
- Extracts every field, identifies the format (R/I/S/B/U/J), builds the sign-extended immediate, and flags illegal encodings.
- Sits between instruction fetch and register read. Valid/ready handshake on both sides, with a 2-entry skid buffer that sustains full throughput under backpressure.
- Carries a flush input and a retired-decode counter.

Parameters:
- XLEN, 32, immediate output width (32 or 64); immediate is sign-extended from bit 31 of the instruction to XLEN.
- CNT_W, 32, width of the decoded-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  discard all buffered entries.
- in_valid  input  1  fetch offers an instruction.
- in_ready  output  1  stage can accept (registered).
- instruction  input  32  raw instruction word.
- out_valid  output  1  decoded entry present.
- out_ready  input  1  consumer accepts.
- opcode  output  7  instr[6:0].
- rd  output  5  instr[11:7].
- func3  output  3  instr[14:12].
- rs1  output  5  instr[19:15].
- rs2  output  5  instr[24:20].
- func7  output  7  instr[31:25].
- fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none.
- imm  output  XLEN  sign-extended immediate; 0 for R and none.
- illegal  output  1  encoding not recognised.
- dec_count  output  CNT_W  number of output handshakes.

Behaviour:
- Reset (async, immediate): buffer state EMPTY; out_valid=0; in_ready=1; all field outputs, imm, illegal and dec_count = 0.
- Decode is combinational on the input word. The full decoded record is stored in the buffer, so outputs are always registered.
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N. This is one cycle when the buffer is empty.
- Buffer state machine, with acc = in_valid & in_ready and pop = out_valid & out_ready:
  - EMPTY: acc -> ONE.
  - ONE: acc & !pop -> TWO; pop & !acc -> EMPTY; acc & pop -> ONE (new entry replaces the output entry).
  - TWO: pop -> ONE (skid entry moves to the output); in_ready=0, so no accept is possible.
- in_ready is registered: in_ready = (next state != TWO). Order is strictly FIFO.
- Outputs must hold stable while out_valid=1 and out_ready=0.
- Opcode decode:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111, 0001111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Anything else -> fmt=7, illegal=1.
  - instr[1:0] != 11 -> illegal=1, fmt=7.
- Immediates:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All are sign-extended to XLEN.
- Illegal entries still flow through the buffer with illegal=1. They are not dropped.
- Flush: next state EMPTY, out_valid=0, in_ready=1 after the edge. An input presented in the same cycle is discarded, and any simultaneous pop is ignored. dec_count still increments if pop=1 that cycle.
- dec_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Asserting rst mid-transfer clears everything immediately. Entries are lost and no output is produced.

Test Plan:
- Reset, then 0xFFB10093 (ADDI x1,x2,-5) with out_ready=1 -> next cycle out_valid=1, fmt=1, rd=1, rs1=2, func3=0, imm=0xFFFFFFFB, illegal=0, dec_count=1 one cycle after pop.
- Stream 0x00532423 (SW x5,8(x6)), 0xFE000EE3 (BEQ x0,x0,-4), 0x123451B7 (LUI x3,0x12345) back-to-back with out_ready=1 -> outputs on consecutive cycles: S imm=8, rs2=5, rs1=6; B imm=0xFFFFFFFC; U rd=3, imm=0x12345000. in_ready stays 1 throughout.
- Hold out_ready=0 and offer 3 instructions -> first two accepted, in_ready=0 from the cycle after the second accept, third held. Release out_ready -> the three are output in order, with no loss or duplication.
- 0x00000000 and 0x0000007F -> illegal=1, fmt=7, imm=0. Both pass through the buffer.
- State TWO, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed entries and the offered word are never output.
- Force dec_count to all-ones with CNT_W=4 over 16 pops -> wraps to 0. Assert rst mid-stream -> all outputs 0 asynchronously.
